// File: rtl/period_meter.sv
// Measures the period of an asynchronous input in clk cycles. It locks once enough
// consecutive measurements agree within a tolerance, and drops the lock on a timeout.
module period_meter #(
  parameter int unsigned STABLE_COUNT = 4,
  parameter int unsigned TOL          = 1,
  parameter int unsigned TIMEOUT      = 1000
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        PWRDWN,
  input  logic        sig_in,
  output logic [31:0] ref_period,
  output logic        period_stable,
  output logic [31:0] meas,
  output logic        meas_valid,
  output logic        timeout
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StArm     = 2'd1,
    StMeasure = 2'd2,
    StLocked  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        sync1_q, sync2_q, hist_q;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] ref_q, ref_d;
  logic [31:0] meas_q, meas_d;
  logic [7:0]  match_q, match_d, match_inc;
  logic        valid_q, valid_d;
  logic        tout_q, tout_d;
  logic [31:0] diff;
  logic        edge_det, in_tol, timed_out, lock_hit;

  // The synchroniser keeps sampling through power-down so no stale edge appears on wake.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= sig_in;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign edge_det  = sync2_q & ~hist_q;
  assign diff      = (cnt_q >= ref_q) ? (cnt_q - ref_q) : (ref_q - cnt_q);
  assign in_tol    = (ref_q != 32'd0) && (diff <= TOL);
  assign timed_out = !edge_det && (cnt_q >= TIMEOUT);
  assign match_inc = match_q + 8'd1;
  assign lock_hit  = (32'(match_inc) >= STABLE_COUNT);

  always_comb begin
    cnt_d = cnt_q;
    if (PWRDWN) begin
      cnt_d = 32'd0;
    end else if (edge_det) begin
      cnt_d = 32'd1;
    end else if (cnt_q != 32'hFFFF_FFFF) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    meas_d  = meas_q;
    match_d = match_q;
    valid_d = 1'b0;
    tout_d  = 1'b0;
    if (PWRDWN) begin
      state_d = StIdle;
      ref_d   = 32'd0;
      meas_d  = 32'd0;
      match_d = 8'd0;
    end else begin
      unique case (state_q)
        StIdle: state_d = StArm;
        StArm: begin
          if (edge_det) begin
            state_d = StMeasure;
            match_d = 8'd0;
          end
        end
        StMeasure, StLocked: begin
          // An edge wins over a coincident timeout threshold.
          if (edge_det) begin
            meas_d  = cnt_q;
            valid_d = 1'b1;
            if (in_tol) begin
              if (state_q == StMeasure) begin
                match_d = match_inc;
                if (lock_hit) state_d = StLocked;
              end
            end else begin
              ref_d   = cnt_q;
              match_d = 8'd1;
              state_d = StMeasure;
            end
          end else if (timed_out) begin
            state_d = StArm;
            ref_d   = 32'd0;
            tout_d  = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      cnt_q   <= 32'd0;
      ref_q   <= 32'd0;
      meas_q  <= 32'd0;
      match_q <= 8'd0;
      valid_q <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ref_q   <= ref_d;
      meas_q  <= meas_d;
      match_q <= match_d;
      valid_q <= valid_d;
      tout_q  <= tout_d;
    end
  end

  assign ref_period    = ref_q;
  assign meas          = meas_q;
  assign meas_valid    = valid_q;
  assign timeout       = tout_q;
  assign period_stable = (state_q == StLocked);

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter: lock, tolerance, timeout, power-down, coincidence, reset.
module tb_period_meter;

  logic        clk = 1'b0;
  logic        RST;
  logic        PWRDWN;
  logic        sig_in;
  logic [31:0] ref_period;
  logic        period_stable;
  logic [31:0] meas;
  logic        meas_valid;
  logic        timeout;

  int errors = 0;
  int checks = 0;
  int to_cnt = 0;

  logic        pre_stable, post_stable, post_valid;
  logic [31:0] post_meas;

  period_meter dut (
    .clk           (clk),
    .RST           (RST),
    .PWRDWN        (PWRDWN),
    .sig_in        (sig_in),
    .ref_period    (ref_period),
    .period_stable (period_stable),
    .meas          (meas),
    .meas_valid    (meas_valid),
    .timeout       (timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (timeout === 1'b1) to_cnt <= to_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One sig_in period of p cycles starting 1 time unit after a rising clk edge.
  // The rise is consumed on the 3rd clk edge; snapshots are taken just before and after.
  task automatic period(input int unsigned p);
    sig_in = 1'b1;
    for (int i = 0; i < int'(p); i++) begin
      @(posedge clk);
      #1;
      if (i == int'(p / 2) - 1) sig_in = 1'b0;
      if (i == 1) pre_stable = period_stable;
      if (i == 2) begin
        post_stable = period_stable;
        post_valid  = meas_valid;
        post_meas   = meas;
      end
    end
  endtask

  // From ARM: five square-wave periods of 10 must lock on the 5th detected edge.
  task automatic lock10(input string tag);
    for (int n = 1; n <= 5; n++) begin
      period(10);
      chk({tag, "_valid"}, 32'(post_valid), (n > 1) ? 32'd1 : 32'd0);
      if (n > 1) chk({tag, "_meas"}, post_meas, 32'd10);
      if (n == 4) chk({tag, "_stable4"}, 32'(post_stable), 32'd0);
      if (n == 5) begin
        chk({tag, "_pre5"}, 32'(pre_stable), 32'd0);
        chk({tag, "_stable5"}, 32'(post_stable), 32'd1);
      end
    end
    chk({tag, "_ref"}, ref_period, 32'd10);
  endtask

  initial begin
    int          first_j;
    int          hits;
    logic [31:0] to_ref;
    logic [31:0] to_stable;
    logic [31:0] to_state;
    int          to_base;

    RST = 1'b1;
    PWRDWN = 1'b0;
    sig_in = 1'b0;
    #2;
    chk("rst_ref", ref_period, 32'd0);
    chk("rst_meas", meas, 32'd0);
    chk("rst_stable", 32'(period_stable), 32'd0);
    chk("rst_valid", 32'(meas_valid), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'd0);
    @(posedge clk);
    #1;
    RST = 1'b0;
    @(posedge clk);
    #1;
    chk("arm_state", 32'(dut.state_q), 32'd1);

    lock10("lock");

    // Tolerance: 11, 9, 10 hold the lock; 13 breaks it.
    period(11);
    period(9);
    chk("tol11_meas", post_meas, 32'd11);
    chk("tol11_stable", 32'(post_stable), 32'd1);
    chk("tol11_ref", ref_period, 32'd10);
    period(10);
    chk("tol9_meas", post_meas, 32'd9);
    chk("tol9_stable", 32'(post_stable), 32'd1);
    chk("tol9_ref", ref_period, 32'd10);
    period(13);
    chk("tol10_meas", post_meas, 32'd10);
    chk("tol10_stable", 32'(post_stable), 32'd1);
    period(10);
    chk("tol13_meas", post_meas, 32'd13);
    chk("tol13_stable", 32'(post_stable), 32'd0);
    chk("tol13_ref", ref_period, 32'd13);
    chk("tol13_match", 32'(dut.match_q), 32'd1);
    chk("tol13_state", 32'(dut.state_q), 32'd2);
    for (int n = 1; n <= 4; n++) begin
      period(10);
      if (n == 3) chk("relock_stable3", 32'(post_stable), 32'd0);
    end
    chk("relock_stable", 32'(post_stable), 32'd1);
    chk("relock_ref", ref_period, 32'd10);

    // Timeout: last edge left cnt=1; the pulse follows the clk edge that sees cnt=1000.
    first_j = 0;
    hits = 0;
    to_ref = 32'hDEAD;
    to_stable = 32'hDEAD;
    to_state = 32'hDEAD;
    for (int j = 1; j <= 1100; j++) begin
      @(posedge clk);
      #1;
      if (timeout === 1'b1) begin
        hits++;
        if (first_j == 0) begin
          first_j = j;
          to_ref = ref_period;
          to_stable = 32'(period_stable);
          to_state = 32'(dut.state_q);
        end
      end
    end
    chk("to_cycle", 32'(first_j), 32'd993);
    chk("to_count", 32'(hits), 32'd1);
    chk("to_ref", to_ref, 32'd0);
    chk("to_stable", to_stable, 32'd0);
    chk("to_state", to_state, 32'd1);

    lock10("tolock");

    // Power-down while locked.
    PWRDWN = 1'b1;
    @(posedge clk);
    #1;
    chk("pd_ref", ref_period, 32'd0);
    chk("pd_meas", meas, 32'd0);
    chk("pd_stable", 32'(period_stable), 32'd0);
    chk("pd_valid", 32'(meas_valid), 32'd0);
    chk("pd_timeout", 32'(timeout), 32'd0);
    chk("pd_state", 32'(dut.state_q), 32'd0);
    chk("pd_cnt", dut.cnt_q, 32'd0);
    chk("pd_match", 32'(dut.match_q), 32'd0);
    @(posedge clk);
    #1;
    PWRDWN = 1'b0;
    @(posedge clk);
    #1;
    chk("pd_arm", 32'(dut.state_q), 32'd1);
    lock10("pdlock");

    // Edge lands exactly when cnt reaches TIMEOUT: measurement, no timeout.
    to_base = to_cnt;
    period(1000);
    period(10);
    chk("co_valid", 32'(post_valid), 32'd1);
    chk("co_meas", post_meas, 32'd1000);
    chk("co_ref", ref_period, 32'd1000);
    chk("co_state", 32'(dut.state_q), 32'd2);
    chk("co_notimeout", 32'(to_cnt - to_base), 32'd0);

    // Asynchronous reset mid-MEASURE, observed before the next clk edge.
    #2;
    RST = 1'b1;
    #1;
    chk("ar_ref", ref_period, 32'd0);
    chk("ar_meas", meas, 32'd0);
    chk("ar_stable", 32'(period_stable), 32'd0);
    chk("ar_valid", 32'(meas_valid), 32'd0);
    chk("ar_state", 32'(dut.state_q), 32'd0);
    @(posedge clk);
    #1;
    RST = 1'b0;
    @(posedge clk);
    #1;
    chk("ar_arm", 32'(dut.state_q), 32'd1);
    lock10("arlock");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
